// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter.
// RF_ZERO_REG_EN (see rf_write_arbiter) makes register 0 read-only zero.
package rf_pkg;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int DATA_W   = 16;
    localparam int N_REQ    = 4;
    localparam int PTR_W    = 2;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MOVE = 2;
    localparam int REQ_CSR  = 3;

    function automatic logic [NUM_REGS-1:0] addr_decode(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << a;
    endfunction
endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
// A stall suppresses every grant.
module rr_grant_picker
    import rf_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    input  logic             wr_stall_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] grant_idx_o
);
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // N_REQ is a power of two, so the pointer add wraps for free.
            cand = rr_ptr_i + PTR_W'(k);
            if (!found && !wr_stall_i && req_valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, one-cycle registered output.
// Define RF_ZERO_REG_EN to make register 0 hard-wired zero (writes to it are accepted but dropped).
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    wr_stall,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [NUM_REGS-1:0]     wr_onehot,
    output logic [DATA_W-1:0]       wr_data,
    output logic [7:0]              grant_cnt
);
    logic [N_REQ-1:0]    grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                transfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_wr;

    logic                wr_en_d,     wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_d,   wr_addr_q;
    logic [NUM_REGS-1:0] wr_onehot_d, wr_onehot_q;
    logic [DATA_W-1:0]   wr_data_d,   wr_data_q;
    logic [7:0]          cnt_d,       cnt_q;
    logic [PTR_W-1:0]    rr_ptr_d,    rr_ptr_q;

    rr_grant_picker u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .wr_stall_i  (wr_stall),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Ready is masked during reset so no handshake can complete while held.
    assign req_ready = grant & {N_REQ{rst_n}};
    assign transfer  = |req_ready;
    assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];

`ifdef RF_ZERO_REG_EN
    assign sel_wr = (sel_addr != '0);
`else
    assign sel_wr = 1'b1;
`endif

    always_comb begin
        wr_en_d     = 1'b0;
        wr_onehot_d = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            wr_en_d     = sel_wr;
            wr_onehot_d = sel_wr ? addr_decode(sel_addr) : '0;
            wr_addr_d   = sel_addr;
            wr_data_d   = sel_data;
            cnt_d       = cnt_q + 8'd1;
            rr_ptr_d    = grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_onehot_q <= '0;
            wr_data_q   <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_onehot_q <= wr_onehot_d;
            wr_data_q   <= wr_data_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_onehot = wr_onehot_q;
    assign wr_data   = wr_data_q;
    assign grant_cnt = cnt_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed literal checks, then random traffic against a behavioural model.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wr_stall;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [NUM_REGS-1:0]     wr_onehot;
    logic [DATA_W-1:0]       wr_data;
    logic [7:0]              grant_cnt;

    int total = 0;
    int bad   = 0;

    rf_write_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_onehot (wr_onehot),
        .wr_data   (wr_data),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer pointer, wrap by modulo, writes described as values.
    int          m_ptr;
    int          m_cnt;
    bit          m_en;
    int          m_addr;
    int          m_data;
    int          tcount [N_REQ];
    bit          zero_reg;

    initial begin
`ifdef RF_ZERO_REG_EN
        zero_reg = 1'b1;
`else
        zero_reg = 1'b0;
`endif
    end

    function automatic int pick(input logic [N_REQ-1:0] v, input logic st, input int ptr);
        if (st) return -1;
        for (int k = 0; k < N_REQ; k++)
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= 0;
            m_cnt  <= 0;
            m_en   <= 1'b0;
            m_addr <= 0;
            m_data <= 0;
        end else begin
            automatic int g = pick(req_valid, wr_stall, m_ptr);
            if (g >= 0) begin
                automatic int a = int'(req_addr[g*ADDR_W +: ADDR_W]);
                tcount[g] <= tcount[g] + 1;
                m_ptr     <= (g + 1) % N_REQ;
                m_cnt     <= (m_cnt + 1) % 256;
                m_addr    <= a;
                m_data    <= int'(req_data[g*DATA_W +: DATA_W]);
                m_en      <= !(zero_reg && a == 0);
            end else begin
                m_en <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, 2 time units after the falling edge.
    always @(negedge clk) begin
        #2;
        begin
            automatic int g = pick(req_valid, wr_stall, m_ptr);
            automatic logic [N_REQ-1:0] er = (rst_n && g >= 0) ? N_REQ'(1 << g) : '0;
            automatic logic [NUM_REGS-1:0] eo = m_en ? NUM_REGS'(1 << m_addr) : '0;
            chk("m_ready",  32'(req_ready), 32'(er));
            chk("m_wr_en",  32'(wr_en),     32'(m_en));
            chk("m_onehot", 32'(wr_onehot), 32'(eo));
            chk("m_addr",   32'(wr_addr),   32'(m_addr));
            chk("m_data",   32'(wr_data),   32'(m_data));
            chk("m_cnt",    32'(grant_cnt), 32'(m_cnt));
        end
    end

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    int last_seen [N_REQ];

    initial begin
        for (int i = 0; i < N_REQ; i++) tcount[i] = 0;
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; wr_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_wr_en", 32'(wr_en), 32'h0);
            chk("idle_onehot", 32'(wr_onehot), 32'h0);
            chk("idle_cnt", 32'(grant_cnt), 32'h0);
        end

        // Fairness from pointer 0: all four held valid for 8 cycles.
        for (int i = 0; i < N_REQ; i++) set_req(i, ADDR_W'(i + 1), DATA_W'(16'hA000 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_ready", 32'(req_ready), 32'(1 << (k % 4)));
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        chk("fair_cnt", 32'(grant_cnt), 32'd8);
        chk("fair_addr", 32'(wr_addr), 32'd4);
        chk("fair_onehot", 32'(wr_onehot), 32'h0010);

        // Single request from requester 1.
        @(negedge clk);
        set_req(1, 4'd5, 16'hBEEF);
        req_valid = 4'b0010;
        #1 chk("single_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        chk("single_wr_en", 32'(wr_en), 32'h1);
        chk("single_addr", 32'(wr_addr), 32'd5);
        chk("single_onehot", 32'(wr_onehot), 32'h0020);
        chk("single_data", 32'(wr_data), 32'hBEEF);
        chk("single_cnt", 32'(grant_cnt), 32'd9);

        // Stall with all valid; pointer now sits at 2.
        @(negedge clk);
        req_valid = 4'b1111; wr_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1 chk("stall_wr_en", 32'(wr_en), 32'h0);
            @(negedge clk);
        end
        wr_stall = 1'b0;
        #1 chk("stall_after", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;

        // Requester 3 writing register 0; pointer now at 3.
        @(negedge clk);
        set_req(3, 4'd0, 16'h1234);
        req_valid = 4'b1000;
        #1 chk("zero_ready", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        chk("zero_cnt", 32'(grant_cnt), 32'd11);
        if (zero_reg) begin
            chk("zero_wr_en", 32'(wr_en), 32'h0);
            chk("zero_onehot", 32'(wr_onehot), 32'h0);
        end else begin
            chk("zero_wr_en", 32'(wr_en), 32'h1);
            chk("zero_onehot", 32'(wr_onehot), 32'h0001);
        end

        // Async reset while a write to register 15 is on the port.
        @(negedge clk);
        set_req(0, 4'd15, 16'h5A5A);
        req_valid = 4'b0001;
        @(posedge clk); #2;
        chk("arst_pre_en", 32'(wr_en), 32'h1);
        chk("arst_pre_addr", 32'(wr_addr), 32'd15);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'h0);
        chk("arst_onehot", 32'(wr_onehot), 32'h0);
        chk("arst_cnt", 32'(grant_cnt), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1 chk("arst_first", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;

        // Random traffic: requesters hold until their transfer is seen by the model.
        for (int i = 0; i < N_REQ; i++) last_seen[i] = tcount[i];
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || tcount[i] != last_seen[i]) begin
                    last_seen[i] = tcount[i];
                    if ($urandom_range(2) != 0) begin
                        req_valid[i] = 1'b1;
                        set_req(i, ADDR_W'($urandom_range(15)), DATA_W'($urandom));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            wr_stall = ($urandom_range(3) == 0);
        end
        @(negedge clk);
        req_valid = '0; wr_stall = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port among 4 requesters (ALU, load unit, move unit, CSR/immediate unit) using round-robin arbitration.
- Registers the winning request and drives the write port:
  - wr_en
  - 4-bit wr_addr
  - 16-bit one-hot wr_onehot (the decoded enable vector for the 16 registers)
  - wr_data
- Sits between the execute/writeback stages and the 16-entry register file.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 for this revision, with pointer width 2.
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W = 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_W  destination register; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  grant; one-hot or zero, combinational.
- wr_stall  in  1  register file busy; blocks new grants.
- wr_en  out  1  registered write strobe.
- wr_addr  out  ADDR_W  registered write address.
- wr_onehot  out  NUM_REGS  registered decoded enable; equals (1 << wr_addr) when wr_en=1, else 0.
- wr_data  out  DATA_W  registered write data.
- grant_cnt  out  8  number of accepted transfers, wraps.

Behaviour:
- Reset (async, rst_n=0):
  - wr_en=0, wr_addr=0, wr_onehot=16'h0000, wr_data=0.
  - grant_cnt=0; round-robin pointer rr_ptr=0.
  - req_ready is 0 while in reset.
- Handshake:
  - A transfer occurs on requester i in the cycle where req_valid[i] & req_ready[i] at the rising clk.
  - A requester holds valid, addr and data stable until it sees ready.
- Grant:
  - If wr_stall=0 and any req_valid is set, grant the first valid requester searching from rr_ptr upward, modulo N_REQ.
  - At most one req_ready bit is high.
  - If wr_stall=1 or no valid request, req_ready=0.
- Pointer update: on a transfer from requester g, rr_ptr <= (g+1) mod N_REQ. With no transfer, rr_ptr holds.
- Latency: 1 cycle. The granted address and data appear on wr_addr/wr_data with wr_en=1 on the clock edge after the handshake cycle.
- Output hold:
  - If no transfer occurs, wr_en=0 and wr_onehot=0 next cycle.
  - wr_addr and wr_data hold their last value.
- wr_onehot is computed from the granted address before registering, so it is aligned with wr_en; it is never combinational from inputs.
- grant_cnt increments by 1 per transfer and wraps 255 -> 0.
- Simultaneous events:
  - All 4 valid continuously gives a strict grant order of rr_ptr, rr_ptr+1, and so on.
  - wr_stall asserted in the same cycle as valid gives no grant; the pointer is unchanged.
- Two requesters targeting the same address in consecutive cycles both write, in grant order; there is no merging or hazard checking.
- Reset mid-transfer: a pending unaccepted request is dropped from the arbiter's view. Outputs go to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired zero.
  - A granted request with addr=0 still completes the handshake (ready=1) and still counts in grant_cnt.
  - It produces wr_en=0 and wr_onehot=0 next cycle.
- Undefined: addr=0 is written like any other register (wr_onehot=16'h0001).

Decomposition:
- Shared package rf_pkg holds:
  - constants ADDR_W=4, NUM_REGS=16, DATA_W=16, N_REQ=4
  - requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MOVE=2, REQ_CSR=3
- One sub-module, rr_grant_picker, is natural. It is purely combinational.
  - Inputs: req_valid, rr_ptr, wr_stall.
  - Outputs: grant one-hot and grant index.
- The output register, pointer, counter and one-hot decode live in the top module.

Test Plan:
- Reset release, no requests, wr_stall=0:
  - wr_en=0, wr_onehot=16'h0000, grant_cnt=0, req_ready=0 for 10 cycles.
- Single request, req_valid=4'b0010, requester 1 addr=4'd5, data=16'hBEEF:
  - req_ready=4'b0010 that cycle.
  - Next cycle wr_en=1, wr_addr=5, wr_onehot=16'h0020, wr_data=16'hBEEF, grant_cnt=1.
- Fairness, all 4 valid held for 8 cycles from rr_ptr=0:
  - Grants go 0,1,2,3,0,1,2,3.
  - grant_cnt=8.
- Stall, all valid with wr_stall=1 for 3 cycles, then 0:
  - No req_ready during stall and wr_en=0; the first grant afterwards goes to the same requester that would have won before the stall.
- RF_ZERO_REG_EN defined, requester 3 addr=0, data=16'h1234:
  - req_ready[3]=1 and grant_cnt increments.
  - Next cycle wr_en=0, wr_onehot=0.
  - With the macro undefined, wr_onehot=16'h0001 instead.
- Async reset mid-stream, rst_n=0 asserted between clock edges while wr_en=1 (addr=4'd15):
  - Outputs clear immediately to wr_en=0, wr_onehot=0.
  - After release, the first grant goes to requester 0.
